// File: rtl/m7_mc_rx_decoder.sv
// m7_mc_rx_decoder: channel-7 Manchester receiver that finds the head sync and decodes 16-bit words
// Samples the synchronized boi/bzi pair once per half-bit and checks code, frame and overrun errors.
module m7_mc_rx_decoder #(
    parameter int HALF_BIT_CLKS = 4,
    parameter int PRE_MIN = 8,
    parameter int IDLE_HB = 4
) (
    input  logic        clock_57,
    input  logic        reset_,
    input  logic        m7_boi,
    input  logic        m7_bzi,
    input  logic        rx_ack,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        rx_busy,
    output logic        code_err,
    output logic        frame_err,
    output logic        overrun
);
    localparam int PW = $clog2(HALF_BIT_CLKS);
    localparam int IW = $clog2(IDLE_HB + 1);
    typedef enum logic [2:0] {IDLE = 3'b001, HUNT = 3'b010, DATA = 3'b100} state_t;
    state_t state, state_n;
    logic [1:0] boi_sync, bzi_sync;
    logic boi_d, boi, bzi, sample, h, line_ok, line_idle, alt, prefix;
    logic [PW-1:0] phase, ph;
    logic [5:0] win, win_n, shifted;
    logic [4:0] pre, pre_n, hb, hb_n;
    logic [IW-1:0] idle, idle_n;
    logic first, first_n;
    logic [15:0] word, word_n, rx_data_n;
    logic rx_valid_n, overrun_n, code_err_n, frame_err_n;

    assign boi = boi_sync[1];
    assign bzi = bzi_sync[1];
    // a boi edge marks the start of a half-bit, so it becomes phase 0 on the spot
    assign ph = (boi != boi_d) ? '0 : phase;
    assign sample = ph == PW'(HALF_BIT_CLKS / 2);
    assign h = boi;
    assign line_ok = boi != bzi;
    assign line_idle = boi & bzi;
    assign shifted = {win[4:0], h};
    assign alt = h != win[0];
    // the sync itself contains non-alternations; they must not wipe a qualified preamble
    assign prefix = shifted[1:0] == 2'b00 || shifted[4:0] == 5'b00011;
    assign rx_busy = state == DATA;

    always_comb begin
        state_n = state;
        win_n = win;
        pre_n = pre;
        idle_n = idle;
        hb_n = hb;
        first_n = first;
        word_n = word;
        rx_data_n = rx_data;
        rx_valid_n = rx_valid & ~rx_ack;
        overrun_n = overrun & ~rx_ack;
        code_err_n = 1'b0;
        frame_err_n = 1'b0;
        if (sample) begin
            win_n = shifted;
            case (state)
                IDLE: if (line_ok) begin
                    state_n = HUNT;
                    pre_n = 5'd1;
                    idle_n = '0;
                end
                HUNT: begin
                    idle_n = line_ok ? '0 : idle + 1'b1;
                    if (!line_ok) begin
                        pre_n = '0;
                        if (idle_n == IW'(IDLE_HB)) state_n = IDLE;
                    end else if (shifted == 6'b000111 && pre >= 5'(PRE_MIN)) begin
                        state_n = DATA;
                        hb_n = '0;
                    end else if (alt) pre_n = (pre == 5'd31) ? pre : pre + 1'b1;
                    else if (!(prefix && pre >= 5'(PRE_MIN))) pre_n = '0;
                end
                DATA: if (line_idle) begin
                    idle_n = idle + 1'b1;
                    if (idle_n == IW'(IDLE_HB)) begin
                        state_n = IDLE;
                        frame_err_n = hb != '0;
                    end
                end else if (idle != '0 || !line_ok || (hb[0] && first == h)) begin
                    state_n = HUNT;
                    pre_n = '0;
                    idle_n = '0;
                    code_err_n = 1'b1;
                end else begin
                    first_n = h;
                    hb_n = hb + 1'b1;
                    if (hb[0]) word_n = {word[14:0], h};
                    if (hb == 5'd31) begin
                        rx_data_n = word_n;
                        rx_valid_n = 1'b1;
                        overrun_n = (overrun | rx_valid) & ~rx_ack;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(negedge clock_57 or negedge reset_) begin
        if (!reset_) begin
            boi_sync <= 2'b11;
            bzi_sync <= 2'b11;
            boi_d <= 1'b1;
            phase <= '0;
            state <= IDLE;
            win <= '1;
            pre <= '0;
            idle <= '0;
            hb <= '0;
            first <= 1'b0;
            word <= '0;
            rx_data <= '0;
            rx_valid <= 1'b0;
            overrun <= 1'b0;
            code_err <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            boi_sync <= {boi_sync[0], m7_boi};
            bzi_sync <= {bzi_sync[0], m7_bzi};
            boi_d <= boi;
            phase <= (ph == PW'(HALF_BIT_CLKS - 1)) ? '0 : ph + 1'b1;
            state <= state_n;
            win <= win_n;
            pre <= pre_n;
            idle <= idle_n;
            hb <= hb_n;
            first <= first_n;
            word <= word_n;
            rx_data <= rx_data_n;
            rx_valid <= rx_valid_n;
            overrun <= overrun_n;
            code_err <= code_err_n;
            frame_err <= frame_err_n;
        end
    end
endmodule
